// File: rtl/lcd_pkg.sv
// Shared constants, command classes and address stepping for the HD44780 bus monitor.
package lcd_pkg;

  typedef enum logic [1:0] {INIT8, HI, LO} lcd_state_e;

  typedef enum logic [3:0] {
    NOP, CLR, HOME, ENTRY, DISP, SHIFT, FUNC, CGRAM, DDRAM
  } cmd_e;

  localparam logic [7:0]   SPACE     = 8'h20;
  localparam logic [6:0]   ROW1_BASE = 7'h00;
  localparam logic [6:0]   ROW2_BASE = 7'h40;
  localparam logic [6:0]   ROW1_END  = 7'h27;
  localparam logic [6:0]   ROW2_END  = 7'h67;
  localparam int           ROW_CHARS = 16;
  localparam logic [127:0] BLANK_ROW = {ROW_CHARS{SPACE}};

  // The highest set bit of a command byte selects its class.
  function automatic cmd_e cmd_class(input logic [7:0] b);
    cmd_e c;
    if (b[7])      c = DDRAM;
    else if (b[6]) c = CGRAM;
    else if (b[5]) c = FUNC;
    else if (b[4]) c = SHIFT;
    else if (b[3]) c = DISP;
    else if (b[2]) c = ENTRY;
    else if (b[1]) c = HOME;
    else if (b[0]) c = CLR;
    else           c = NOP;
    return c;
  endfunction

  // DDRAM address walk: each line is 40 bytes; the two lines chain into a ring.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
    logic [6:0] n;
    if (up) begin
      if (a == ROW1_END)      n = ROW2_BASE;
      else if (a == ROW2_END) n = ROW1_BASE;
      else                    n = a + 7'd1;
    end else begin
      if (a == ROW2_BASE)      n = ROW1_END;
      else if (a == ROW1_BASE) n = ROW2_END;
      else                     n = a - 7'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the LCD bus plus E falling-edge detection.
module lcd_bus_sync (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       e,
  input  logic       rs,
  input  logic       rw,
  input  logic [3:0] d,
  output logic       fall,
  output logic       rs_s,
  output logic       rw_s,
  output logic [3:0] d_s
);

  // Bus packed as {e, rs, rw, d} so all lines see identical delay.
  logic [6:0] s1, s2;
  logic       prev_e;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1     <= '0;
      s2     <= '0;
      prev_e <= 1'b0;
    end else begin
      s1     <= {e, rs, rw, d};
      s2     <= s1;
      prev_e <= s2[6];
    end
  end

  assign fall = ~s2[6] & prev_e;
  assign rs_s = s2[5];
  assign rw_s = s2[4];
  assign d_s  = s2[3:0];

endmodule

// File: rtl/lcd_bus_monitor.sv
// Decodes HD44780 4-bit bus writes and mirrors the two visible 16-char rows.
module lcd_bus_monitor
  import lcd_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         LCD_E,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  input  logic [3:0]   LCD_D,
  output logic [127:0] row_A,
  output logic [127:0] row_B,
  output logic         disp_on,
  output logic         bus_4bit,
  output logic         byte_valid,
  output logic         byte_rs,
  output logic [7:0]   byte_data
);

  logic       fall, rs_s, rw_s;
  logic [3:0] d_s;

  lcd_bus_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .e       (LCD_E),
    .rs      (LCD_RS),
    .rw      (LCD_RW),
    .d       (LCD_D),
    .fall    (fall),
    .rs_s    (rs_s),
    .rw_s    (rw_s),
    .d_s     (d_s)
  );

  lcd_state_e state, state_nx;
  logic [3:0] hi_q;
  logic [6:0] addr;
  logic       inc, cg;

  // Read strobes never advance the nibble phase.
  logic       stb;
  logic [7:0] byte_w;
  cmd_e       cls;

  assign stb    = fall & ~rw_s;
  assign byte_w = {hi_q, d_s};
  assign cls    = cmd_class(byte_w);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= INIT8;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (stb) begin
      case (state)
        INIT8:   if (d_s == 4'h2) state_nx = HI;
        HI:      state_nx = LO;
        LO:      state_nx = (!rs_s && cls == FUNC && byte_w[4]) ? INIT8 : HI;
        default: state_nx = INIT8;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_A      <= BLANK_ROW;
      row_B      <= BLANK_ROW;
      disp_on    <= 1'b0;
      bus_4bit   <= 1'b0;
      byte_valid <= 1'b0;
      byte_rs    <= 1'b0;
      byte_data  <= '0;
      hi_q       <= '0;
      addr       <= ROW1_BASE;
      inc        <= 1'b1;
      cg         <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (stb) begin
        case (state)
          INIT8: if (d_s == 4'h2) bus_4bit <= 1'b1;
          HI:    hi_q <= d_s;
          LO: begin
            byte_valid <= 1'b1;
            byte_rs    <= rs_s;
            byte_data  <= byte_w;
            if (!rs_s) begin
              case (cls)
                CLR: begin
                  row_A <= BLANK_ROW;
                  row_B <= BLANK_ROW;
                  addr  <= ROW1_BASE;
                  inc   <= 1'b1;
                end
                HOME:  addr    <= ROW1_BASE;
                ENTRY: inc     <= byte_w[1];
                DISP:  disp_on <= byte_w[2];
                SHIFT: if (!byte_w[3]) addr <= step_addr(addr, byte_w[2]);
                FUNC:  if (byte_w[4]) bus_4bit <= 1'b0;
                CGRAM: cg <= 1'b1;
                DDRAM: begin
                  addr <= byte_w[6:0];
                  cg   <= 1'b0;
                end
                default: ;
              endcase
            end else if (!cg) begin
              // Only the first 16 cells of each line are visible.
              if (addr[6:4] == 3'b000)
                row_A[(ROW_CHARS - 1 - int'(addr[3:0])) * 8 +: 8] <= byte_w;
              else if (addr[6:4] == 3'b100)
                row_B[(ROW_CHARS - 1 - int'(addr[3:0])) * 8 +: 8] <= byte_w;
              addr <= step_addr(addr, inc);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Randomized scoreboard bench for lcd_bus_monitor against a DDRAM-level model.
module tb_lcd_bus_monitor;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         LCD_E = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
  logic [3:0]   LCD_D = 4'h0;
  logic [127:0] row_A, row_B;
  logic         disp_on, bus_4bit, byte_valid, byte_rs;
  logic [7:0]   byte_data;

  lcd_bus_monitor dut (
    .clk(clk), .reset_n(reset_n), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_D(LCD_D), .row_A(row_A), .row_B(row_B), .disp_on(disp_on), .bus_4bit(bus_4bit),
    .byte_valid(byte_valid), .byte_rs(byte_rs), .byte_data(byte_data)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, npop = 0;
  logic [8:0] exp_q[$];

  // Model: character cells, a linear 80-cell DDRAM position, entry flags.
  byte ma[16], mb[16];
  int  maddr, minc, mcg, mdisp, m4, mhiph;
  logic [3:0] mhi;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int mstep(input int a, input bit up);
    int pos;
    if (a <= 39) pos = a;
    else if (a >= 64 && a <= 103) pos = a - 24;
    else return (a + (up ? 1 : 127)) % 128;
    pos = (pos + (up ? 1 : 79)) % 80;
    return (pos < 40) ? pos : pos + 24;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin ma[i] = 8'h20; mb[i] = 8'h20; end
    maddr = 0; minc = 1; mcg = 0; mdisp = 0; m4 = 0; mhiph = 1; mhi = 0;
  endtask

  task automatic model_exec(input bit rs, input logic [7:0] b);
    if (rs) begin
      if (mcg) return;
      if (maddr < 16) ma[maddr] = b;
      else if (maddr >= 64 && maddr < 80) mb[maddr - 64] = b;
      maddr = mstep(maddr, minc != 0);
    end else if (b[7]) begin maddr = int'(b[6:0]); mcg = 0; end
    else if (b[6]) mcg = 1;
    else if (b[5]) begin if (b[4]) m4 = 0; end
    else if (b[4]) begin if (!b[3]) maddr = mstep(maddr, b[2]); end
    else if (b[3]) mdisp = b[2];
    else if (b[2]) minc = b[1];
    else if (b[1]) maddr = 0;
    else if (b[0]) begin
      for (int i = 0; i < 16; i++) begin ma[i] = 8'h20; mb[i] = 8'h20; end
      maddr = 0; minc = 1;
    end
  endtask

  task automatic model_nibble(input bit rs, input bit rw, input logic [3:0] d);
    logic [7:0] b;
    if (rw) return;
    if (!m4) begin
      if (d == 4'h2) begin m4 = 1; mhiph = 1; end
    end else if (mhiph) begin
      mhi = d; mhiph = 0;
    end else begin
      b = {mhi, d}; mhiph = 1;
      exp_q.push_back({rs, b});
      model_exec(rs, b);
    end
  endtask

  function automatic logic [127:0] pack(input byte r[16]);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = r[i];
    return v;
  endfunction

  function automatic logic [127:0] str_row(input string s);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = s[i];
    return v;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " row_A"}, row_A, pack(ma));
    chk({tag, " row_B"}, row_B, pack(mb));
    chk({tag, " disp_on"}, {127'd0, disp_on}, 128'(mdisp));
    chk({tag, " bus_4bit"}, {127'd0, bus_4bit}, 128'(m4));
  endtask

  // E high 4 clk, E low 4 clk; lat=1 checks the 3-cycle output latency.
  task automatic nib(input bit rs, input bit rw, input logic [3:0] d, input bit lat = 1'b0);
    @(negedge clk);
    LCD_RS = rs; LCD_RW = rw; LCD_D = d; LCD_E = 1'b1;
    repeat (4) @(negedge clk);
    LCD_E = 1'b0;
    model_nibble(rs, rw, d);
    if (lat) begin
      @(posedge clk); #1 chk("lat k", {127'd0, byte_valid}, 128'd0);
      @(posedge clk); #1 chk("lat k+1", {127'd0, byte_valid}, 128'd0);
      @(posedge clk); #1 chk("lat k+2", {127'd0, byte_valid}, 128'd1);
      check_model("lat k+2");
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input bit rs, input logic [7:0] b, input bit lat = 1'b0);
    nib(rs, 1'b0, b[7:4]);
    nib(rs, 1'b0, b[3:0], lat);
  endtask

  task automatic send_str(input string s, input bit lat_last = 1'b0);
    for (int i = 0; i < s.len(); i++) send(1'b1, s[i], lat_last && (i == s.len() - 1));
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic init_bus();
    nib(0, 0, 4'h3); nib(0, 0, 4'h3); nib(0, 0, 4'h3); nib(0, 0, 4'h2);
    send(0, 8'h28); send(0, 8'h0C); send(0, 8'h06); send(0, 8'h01);
  endtask

  // Scoreboard monitor.
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge clk); #1;
      if (byte_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL byte_valid unexpected: got %b_%h expected none", byte_rs, byte_data);
        end else begin
          e = exp_q.pop_front();
          chk("byte", {119'd0, byte_rs, byte_data}, {119'd0, e});
          npop++;
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [7:0] b;
    model_reset();
    do_reset();
    check_model("reset");

    nib(0, 0, 4'h3); nib(0, 0, 4'h3); nib(0, 0, 4'h3);
    chk("init8 no 4bit", {127'd0, bus_4bit}, 128'd0);
    nib(0, 0, 4'h2);
    chk("4bit entered", {127'd0, bus_4bit}, 128'd1);
    send(0, 8'h28); send(0, 8'h0C); send(0, 8'h06); send(0, 8'h01);
    check_model("init");
    chk("init pulses", 128'(npop), 128'd4);
    chk("init disp_on", {127'd0, disp_on}, 128'd1);

    send(0, 8'h80); send_str("Press BTN3 to   ");
    send(0, 8'hC0); send_str("show a message..", 1'b1);
    chk("str row_A", row_A, str_row("Press BTN3 to   "));
    chk("str row_B", row_B, str_row("show a message.."));

    send(0, 8'h80); send_str("abcdefghijklmnopq");
    chk("17 bytes row_A", row_A, str_row("abcdefghijklmnop"));
    check_model("17 bytes");

    send(0, 8'hA7); send_str("XY");
    chk("wrap row_B0", 128'(row_B[127 -: 8]), 128'("Y"));

    send(0, 8'h04); send(0, 8'h8F); send_str("AB");
    chk("dec char15", 128'(row_A[7:0]), 128'("A"));
    chk("dec char14", 128'(row_A[15:8]), 128'("B"));
    send(0, 8'h06);
    check_model("dec");

    // Read strobe wedged between the nibbles of a data byte.
    send(0, 8'h85);
    nib(1, 0, 4'h5); nib(1, 1, 4'h9); nib(1, 0, 4'hA);
    chk("rw ignored char5", 128'(row_A[127 - 8*5 -: 8]), 128'h5A);
    check_model("rw");

    // CGRAM writes must not touch the rows or move the address.
    send(0, 8'h40); send_str("zz"); send(0, 8'h80); send_str("Q");
    check_model("cgram");

    for (int n = 0; n < 160; n++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2, 3, 4: begin b = 8'($urandom_range(32, 126)); send(1, b); end
        5: send(0, 8'h80 | 8'($urandom_range(0, 19)));
        6: send(0, 8'hC0 | 8'($urandom_range(0, 19)));
        7: send(0, 8'h10 | 8'($urandom_range(0, 15)));
        8: send(0, 8'h04 | 8'($urandom_range(0, 3)));
        9: send(0, 8'h08 | 8'($urandom_range(0, 7)));
        10: send(0, 8'h02);
        default: nib(1, 1, 4'($urandom_range(0, 15)));
      endcase
      if (n % 16 == 15) check_model("random");
    end
    send(0, 8'h01);
    check_model("clear");

    // Reset mid-byte, then re-enter 4-bit mode with a single nibble 2.
    send(0, 8'h80); send_str("hi");
    nib(1, 0, 4'h4);
    do_reset();
    check_model("midreset");
    nib(0, 0, 4'h2);
    chk("re-4bit", {127'd0, bus_4bit}, 128'd1);
    send(0, 8'h0C); send_str("ok");
    check_model("after reset");

    // Function set with DL=1 drops back to 8-bit mode.
    send(0, 8'h30);
    chk("func 8bit", {127'd0, bus_4bit}, 128'd0);
    nib(0, 0, 4'h2); send(1, 8'h21);
    check_model("func");

    repeat (4) @(negedge clk);
    chk("queue drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
